wb_cmd_master: RTL

- Single-outstanding Wishbone B4 pipelined initiator: converts a valid/ready command stream into one Wishbone cycle per command and returns the result on a valid/ready response stream.
- Drives the register banks generated in this codebase (32-bit data, byte selects, ack/err/rty/stall) from CPU bridges, debug ports or test sequencers.
- Adds a bus timeout so a hung responder cannot lock the initiator.

---
 rtl/wb_cmd_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined initiator: one bus cycle per command, bus timeout.
// Build option: define WB_CMD_MASTER_RETRY_EN to re-issue rty terminations up to MAX_RETRY times.
module wb_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] StatOk  = 2'b00;
    localparam logic [1:0] StatErr = 2'b01;
    localparam logic [1:0] StatTmo = 2'b10;
    localparam logic [1:0] StatRty = 2'b11;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StRetry} state_e;

    state_e                state_q, state_d;
    logic                  live_q;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [31:0]           dat_q, dat_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_dat_q, rsp_dat_d;
    logic [1:0]            rsp_status_q, rsp_status_d;

    logic                  timed_out;
    logic                  respond;
    logic [1:0]            status;
    logic [31:0]           rdata;

`ifdef WB_CMD_MASTER_RETRY_EN
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RtyW-1:0] retry_q, retry_d;
`else
    logic [31:0] unused_max_retry;
    assign unused_max_retry = MAX_RETRY;
`endif

    // Counter holds cycles already spent; this cycle is the TIMEOUT-th one.
    assign timed_out = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    assign cmd_ready_o  = live_q && (state_q == StIdle);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_adr_o     = adr_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_dat_o     = dat_q;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        we_d         = we_q;
        dat_d        = dat_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        respond      = 1'b0;
        status       = StatOk;
        rdata        = '0;
`ifdef WB_CMD_MASTER_RETRY_EN
        retry_d      = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && live_q) begin
                    adr_d   = cmd_adr_i;
                    sel_d   = cmd_sel_i;
                    we_d    = cmd_we_i;
                    dat_d   = cmd_dat_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
`ifdef WB_CMD_MASTER_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = StReq;
                end
            end
            StReq, StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (state_q == StReq && !wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = StWait;
                end
                if (wb_err_i) begin
                    respond = 1'b1;
                    status  = StatErr;
                end else if (wb_rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
                    if (retry_q < RtyW'(MAX_RETRY)) begin
                        retry_d = retry_q + RtyW'(1);
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        state_d = StRetry;
                    end else begin
                        respond = 1'b1;
                        status  = StatRty;
                    end
`else
                    respond = 1'b1;
                    status  = StatRty;
`endif
                end else if (wb_ack_i) begin
                    respond = 1'b1;
                    status  = StatOk;
                    if (!we_q) begin
                        rdata = wb_dat_i;
                    end
                end else if (timed_out) begin
                    respond = 1'b1;
                    status  = StatTmo;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StRetry: begin
`ifdef WB_CMD_MASTER_RETRY_EN
                // One idle cycle with cyc low, then re-issue the same request.
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                cnt_d   = '0;
                state_d = StReq;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        if (respond) begin
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_dat_d    = rdata;
            rsp_status_d = status;
            state_d      = StResp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            live_q       <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            dat_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= StatOk;
`ifdef WB_CMD_MASTER_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            live_q       <= 1'b1;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            dat_q        <= dat_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
`ifdef WB_CMD_MASTER_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

endmodule
